lisnoc_packet_mux: RTL and testbench

Packet-atomic, round-robin multiplexer merging `ports` flit streams onto one NoC link. Sits directly downstream of message-passing endpoints' output packet buffers, so several endpoints share one router input port. A packet, once granted, holds the link until its LAST flit, so flits of different packets never interleave. The output is registered for timing closure at the router boundary.

---
 rtl/lisnoc_packet_mux_pkg.sv | 24 ++
 rtl/lisnoc_arb_rr.sv | 29 ++
 rtl/lisnoc_packet_mux.sv | 120 ++++++++++++
 tb/tb_lisnoc_packet_mux.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lisnoc_packet_mux_pkg.sv
// Shared LISNoC flit definitions and arbitration state used by the packet mux
// and the round-robin arbiter.
package lisnoc_packet_mux_pkg;

    // Flit type codes: low two bits of the type field.
    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic logic is_header(input logic [1:0] flit_type);
        return flit_type == FLIT_TYPE_HEADER;
    endfunction

    function automatic logic is_last(input logic [1:0] flit_type);
        return flit_type == FLIT_TYPE_LAST;
    endfunction

endpackage

// File: rtl/lisnoc_arb_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at
// or above rr_ptr, wrapping modulo ports.
module lisnoc_arb_rr #(
    parameter  int ports = 2,
    localparam int pw    = $clog2(ports)
) (
    input  logic [ports-1:0] req,
    input  logic [pw-1:0]    rr_ptr,
    output logic [ports-1:0] grant
);

    int idx;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = ports - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= ports)
                idx = idx - ports;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisnoc_packet_mux.sv
// Packet-atomic round-robin mux: merges several flit streams onto one link,
// holding the link from HEADER to LAST, with a registered output stage.
module lisnoc_packet_mux
    import lisnoc_packet_mux_pkg::*;
#(
    parameter  int noc_data_width = 32,
    parameter  int noc_type_width = 2,
    parameter  int ports          = 2,
    localparam int fw             = noc_data_width + noc_type_width,
    localparam int pw             = $clog2(ports)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ports*fw-1:0] in_flit,
    input  logic [ports-1:0]    in_valid,
    output logic [ports-1:0]    in_ready,
    output logic [fw-1:0]       out_flit,
    output logic                out_valid,
    input  logic                out_ready
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [pw-1:0]    lock_port;
    logic [pw-1:0]    rr_ptr;
    logic [pw-1:0]    grant_idx;
    logic [pw-1:0]    port_after;
    logic [ports-1:0] req;
    logic [ports-1:0] grant;
    logic [fw-1:0]    sel_flit;
    logic [1:0]       sel_type;
    logic             can_load;
    logic             xfer;

    assign can_load = !out_valid || out_ready;

    // While locked only the owning port may request; the arbiter then grants it.
    always_comb begin
        req = in_valid;
        if (state == ARB_LOCKED) begin
            req            = '0;
            req[lock_port] = in_valid[lock_port];
        end
    end

    lisnoc_arb_rr #(
        .ports (ports)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < ports; i++)
            if (grant[i])
                grant_idx = pw'(i);
    end

    assign sel_flit   = in_flit[grant_idx*fw +: fw];
    assign sel_type   = sel_flit[noc_data_width +: 2];
    assign xfer       = |(in_valid & in_ready);
    assign port_after = (grant_idx == pw'(ports - 1)) ? '0 : grant_idx + pw'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ARB_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:   if (xfer && is_header(sel_type)) state_next = ARB_LOCKED;
            ARB_LOCKED: if (xfer && is_last(sel_type))   state_next = ARB_IDLE;
            default:    state_next = ARB_IDLE;
        endcase
    end

    // Output logic: ready only toward the granted port, and never during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && can_load)
            in_ready = grant;
    end

    // rr_ptr advances past a port only once its packet (or lone flit) is done.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_port <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            if (state == ARB_IDLE) begin
                if (is_header(sel_type))
                    lock_port <= grant_idx;
                else
                    rr_ptr <= port_after;
            end else if (is_last(sel_type)) begin
                rr_ptr <= port_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_flit  <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_flit  <= sel_flit;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lisnoc_packet_mux.sv
// Directed bench for lisnoc_packet_mux with two ports and a 3-bit type field
// so the upper type bit's pass-through is exercised.
module tb_lisnoc_packet_mux;

    localparam int DW = 32;
    localparam int TW = 3;
    localparam int FW = DW + TW;
    localparam int P  = 2;

    localparam logic [2:0] T_PAY  = 3'b000;
    localparam logic [2:0] T_HDR  = 3'b001;
    localparam logic [2:0] T_LAST = 3'b010;
    localparam logic [2:0] T_SGL  = 3'b011;
    localparam logic [2:0] T_HDRX = 3'b101; // HEADER with upper type bit set

    logic            clk;
    logic            rst;
    logic [FW-1:0]   f0, f1;
    logic [P*FW-1:0] in_flit;
    logic [P-1:0]    in_valid;
    logic [P-1:0]    in_ready;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic            out_ready;

    int checks   = 0;
    int failures = 0;

    assign in_flit = {f1, f0};

    lisnoc_packet_mux #(
        .noc_data_width (DW),
        .noc_type_width (TW),
        .ports          (P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [2:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [FW-1:0] exp);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_flit"}, 64'(out_flit), 64'(exp));
    endtask

    initial begin
        // Reset with both ports requesting
        rst = 1'b1; out_ready = 1'b1; in_valid = 2'b11;
        f0 = mk(T_SGL, 32'h1); f1 = mk(T_SGL, 32'h2);
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_flit", 64'(out_flit), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0; #1;
        check("post_rst_grant", 64'(in_ready), 64'b01);

        // Port0 3-flit packet vs port1 SINGLE
        f0 = mk(T_HDRX, 32'hA0); f1 = mk(T_SGL, 32'hB0); in_valid = 2'b11; #1;
        check("pkt_rdy_a0", 64'(in_ready), 64'b01);
        tick();
        check_out("pkt_a0", mk(T_HDRX, 32'hA0));
        f0 = mk(T_PAY, 32'hA1); #1;
        check("pkt_rdy_a1", 64'(in_ready), 64'b01);
        tick();
        check_out("pkt_a1", mk(T_PAY, 32'hA1));
        f0 = mk(T_LAST, 32'hA2); #1;
        check("pkt_rdy_a2", 64'(in_ready), 64'b01);
        tick();
        check_out("pkt_a2", mk(T_LAST, 32'hA2));
        in_valid = 2'b10; #1;
        check("pkt_rdy_b0", 64'(in_ready), 64'b10);
        tick();
        check_out("pkt_b0", mk(T_SGL, 32'hB0));
        in_valid = 2'b00;
        tick();
        check("pkt_drain", 64'(out_valid), 64'd0);

        // Both ports stream SINGLEs: strict alternation, no bubbles
        in_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            f0 = mk(T_SGL, 32'h100 + k); f1 = mk(T_SGL, 32'h200 + k); #1;
            check("alt_rdy", 64'(in_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            check_out("alt_out", (k % 2 == 0) ? mk(T_SGL, 32'h100 + k) : mk(T_SGL, 32'h200 + k));
        end
        in_valid = 2'b00;
        tick();
        check("alt_drain", 64'(out_valid), 64'd0);

        // Backpressure mid-packet
        f0 = mk(T_HDR, 32'hD0); in_valid = 2'b01;
        tick();
        check_out("bp_d0", mk(T_HDR, 32'hD0));
        out_ready = 1'b0; f0 = mk(T_PAY, 32'hD1); f1 = mk(T_SGL, 32'hE0); in_valid = 2'b11; #1;
        check("bp_rdy_stall", 64'(in_ready), 64'b00);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out("bp_hold", mk(T_HDR, 32'hD0));
            check("bp_hold_rdy", 64'(in_ready), 64'b00);
        end
        out_ready = 1'b1; #1;
        check("bp_rdy_release", 64'(in_ready), 64'b01);
        tick();
        check_out("bp_d1", mk(T_PAY, 32'hD1));
        f0 = mk(T_LAST, 32'hD2); #1;
        check("bp_rdy_d2", 64'(in_ready), 64'b01);
        tick();
        check_out("bp_d2", mk(T_LAST, 32'hD2));
        in_valid = 2'b10; #1;
        check("bp_rdy_e0", 64'(in_ready), 64'b10);
        tick();
        check_out("bp_e0", mk(T_SGL, 32'hE0));
        in_valid = 2'b00;
        tick();

        // Stray LAST while idle: one-flit unit, then port1 has priority
        f0 = mk(T_LAST, 32'hC0); in_valid = 2'b01; #1;
        check("stray_rdy", 64'(in_ready), 64'b01);
        tick();
        check_out("stray_c0", mk(T_LAST, 32'hC0));
        f0 = mk(T_SGL, 32'hC1); f1 = mk(T_SGL, 32'hC8); in_valid = 2'b11; #1;
        check("stray_rr", 64'(in_ready), 64'b10);
        tick();
        check_out("stray_next", mk(T_SGL, 32'hC8));
        in_valid = 2'b00;
        tick();

        // Reset after the HEADER of a 4-flit packet
        f0 = mk(T_HDR, 32'hF0); in_valid = 2'b01;
        tick();
        check_out("mid_f0", mk(T_HDR, 32'hF0));
        rst = 1'b1; f0 = mk(T_PAY, 32'hF1); in_valid = 2'b11; #1;
        check("mid_rst_rdy", 64'(in_ready), 64'b00);
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_flit", 64'(out_flit), 64'd0);
        rst = 1'b0; f1 = mk(T_SGL, 32'h60); in_valid = 2'b10; #1;
        check("mid_rdy_g0", 64'(in_ready), 64'b10);
        tick();
        check_out("mid_g0", mk(T_SGL, 32'h60));
        in_valid = 2'b00;
        tick();
        check("end_drain", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
